// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - host-side FIFO read and error-clear bundle for the PS/2 receiver
interface ps2_rx_fifo_if #(
    parameter int FIFO_AW = 4
);
    logic               rd_stb_i;
    logic               err_clr_i;
    logic [7:0]         rx_data_o;
    logic               rx_empty_o;
    logic [FIFO_AW:0]   rx_count_o;
    logic               overflow_o;

    modport slave (
        input  rd_stb_i, err_clr_i,
        output rx_data_o, rx_empty_o, rx_count_o, overflow_o
    );

    modport master (
        output rd_stb_i, err_clr_i,
        input  rx_data_o, rx_empty_o, rx_count_o, overflow_o
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with glitch filter, frame timeout and FWFT scan-code FIFO
// Optional odd-parity checking is enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FIFO_AW        = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ps2_clk_i,
    input  logic              ps2_din_i,
    ps2_rx_fifo_if.slave      bus,
    output logic              frame_err_o,
    output logic              parity_err_o
);
    localparam int FW    = $clog2(FILTER_LEN);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic            clk_meta_q, clk_s_q, din_meta_q, din_s_q;
    logic            filt_q, filt_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            fe;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            timeout, parity_ok, push;

    logic [7:0]          mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                pop, full, wr_en, ovf_set;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_meta_q <= 1'b1;
            clk_s_q    <= 1'b1;
            din_meta_q <= 1'b1;
            din_s_q    <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
        end else begin
            clk_meta_q <= ps2_clk_i;
            clk_s_q    <= clk_meta_q;
            din_meta_q <= ps2_din_i;
            din_s_q    <= din_meta_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive sample that disagrees with it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fe     = 1'b0;
        if (clk_s_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s_q;
                fe     = filt_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

`ifdef PS2_RX_PARITY_CHECK_EN
    logic par_q, par_d;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) par_q <= 1'b0;
        else          par_q <= par_d;
    end
    always_comb begin
        par_d = par_q;
        if (fe && state_q == PARITY) par_d = din_s_q;
    end
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            to_q      <= to_d;
        end
    end

    assign timeout = (state_q != IDLE) && (to_q == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_d      = to_q;
        if (state_q == IDLE || fe || timeout) to_d = '0;
        else                                  to_d = to_q + TO_W'(1);
        if (timeout) begin
            state_d = IDLE;
        end else if (fe) begin
            case (state_q)
                IDLE: if (!din_s_q) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d   = {din_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY:  state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    // A bad stop bit outranks a parity mismatch.
    always_comb begin
        push         = 1'b0;
        frame_err_o  = 1'b0;
        parity_err_o = 1'b0;
        if (timeout) begin
            frame_err_o = 1'b1;
        end else if (fe && state_q == STOP) begin
            if (!din_s_q)        frame_err_o  = 1'b1;
            else if (!parity_ok) parity_err_o = 1'b1;
            else                 push         = 1'b1;
        end
    end

    assign pop     = bus.rd_stb_i && (count_q != '0);
    assign full    = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop)      count_d = count_q + (FIFO_AW + 1)'(1);
        else if (!wr_en && pop) count_d = count_q - (FIFO_AW + 1)'(1);
        overflow_d = overflow_q;
        if (ovf_set)            overflow_d = 1'b1;
        else if (bus.err_clr_i) overflow_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bus.rx_data_o  = mem_q[rd_ptr_q];
    assign bus.rx_empty_o = (count_q == '0);
    assign bus.rx_count_o = count_q;
    assign bus.overflow_o = overflow_q;
endmodule
